// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUOp values, R-type opcodes, internal control encoding
// and the decode from (ALUOp, opcode) to that encoding.
package alu_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_PASSB = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [10:0] OPC_ADD = 11'b10001011000;
   localparam logic [10:0] OPC_SUB = 11'b11001011000;
   localparam logic [10:0] OPC_AND = 11'b10001010000;
   localparam logic [10:0] OPC_ORR = 11'b10101010000;
   localparam logic [10:0] OPC_EOR = 11'b11001010000;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_ORR,
      ALU_EOR,
      ALU_PASSB,
      ALU_ILLEGAL
   } alu_ctrl_e;

   function automatic alu_ctrl_e alu_decode(input logic [1:0] alu_op, input logic [10:0] opcode);
      alu_ctrl_e ctrl;
      ctrl = ALU_ILLEGAL;
      case (alu_op)
         ALUOP_ADD:   ctrl = ALU_ADD;
         ALUOP_PASSB: ctrl = ALU_PASSB;
         ALUOP_RTYPE: begin
            case (opcode)
               OPC_ADD: ctrl = ALU_ADD;
               OPC_SUB: ctrl = ALU_SUB;
               OPC_AND: ctrl = ALU_AND;
               OPC_ORR: ctrl = ALU_ORR;
               OPC_EOR: ctrl = ALU_EOR;
               default: ctrl = ALU_ILLEGAL;
            endcase
         end
         default:     ctrl = ALU_ILLEGAL;
      endcase
      return ctrl;
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational LEGv8 ALU: control decode plus result, zero and illegal flags.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = 64
) (
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [1:0]        i_alu_op,
   input  logic [10:0]       i_opcode,
   output logic [DATA_W-1:0] o_result,
   output logic              o_zero,
   output logic              o_illegal
);

   alu_ctrl_e w_ctrl;

   assign w_ctrl = alu_decode(i_alu_op, i_opcode);

   always_comb begin
      o_result  = '0;
      o_illegal = 1'b0;
      case (w_ctrl)
         ALU_ADD:   o_result = i_a + i_b;
         ALU_SUB:   o_result = i_a - i_b;
         ALU_AND:   o_result = i_a & i_b;
         ALU_ORR:   o_result = i_a | i_b;
         ALU_EOR:   o_result = i_a ^ i_b;
         ALU_PASSB: o_result = i_b;
         default:   o_illegal = 1'b1;
      endcase
   end

   assign o_zero = (o_result == '0);

endmodule

// File: rtl/regfile_alu_pipe.sv
// Two-stage execute block: register file with X/W bypass feeding alu_core,
// valid/ready handshakes on both sides and in-order writeback on retirement.
module regfile_alu_pipe
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned REG_COUNT = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned ZERO_REG  = 31
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_read1,
   input  logic [ADDR_W-1:0] in_read2,
   input  logic [ADDR_W-1:0] in_write_reg,
   input  logic              in_reg_write,
   input  logic [1:0]        in_alu_op,
   input  logic [10:0]       in_opcode,
   input  logic [DATA_W-1:0] in_imm,
   input  logic              in_use_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_zero,
   output logic              out_illegal,
   output logic [ADDR_W-1:0] out_write_reg
);

   localparam logic [ADDR_W-1:0] ZR     = ADDR_W'(ZERO_REG);
   localparam logic [ADDR_W:0]   NREGS  = (ADDR_W+1)'(REG_COUNT);

   logic [DATA_W-1:0] r_regs [REG_COUNT];

   logic              r_x_valid;
   logic [DATA_W-1:0] r_x_a;
   logic [DATA_W-1:0] r_x_b;
   logic [1:0]        r_x_alu_op;
   logic [10:0]       r_x_opcode;
   logic [ADDR_W-1:0] r_x_write_reg;
   logic              r_x_reg_write;

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_result;
   logic              r_out_zero;
   logic              r_out_illegal;
   logic [ADDR_W-1:0] r_out_write_reg;
   logic              r_w_reg_write;

   logic [DATA_W-1:0] w_alu_result;
   logic              w_alu_zero;
   logic              w_alu_illegal;
   logic              w_free;
   logic              w_x_adv;
   logic              w_in_ready;
   logic              w_accept;
   logic              w_x_wr_en;
   logic              w_retire_wr;
   logic [ADDR_W-1:0] w_src [2];
   logic [DATA_W-1:0] w_rd  [2];

   assign w_free     = !r_out_valid || out_ready;
   assign w_x_adv    = r_x_valid && w_free;
   assign w_in_ready = !r_x_valid || w_free;
   assign w_accept   = in_valid && w_in_ready;

   // Illegal results never reach the register file, so they must not be bypassed either.
   assign w_x_wr_en   = r_x_reg_write && !w_alu_illegal;
   assign w_retire_wr = r_out_valid && out_ready && r_w_reg_write &&
                        (r_out_write_reg != ZR) && ({1'b0, r_out_write_reg} < NREGS);

   assign w_src[0] = in_read1;
   assign w_src[1] = in_read2;

   always_comb begin
      for (int unsigned s = 0; s < 2; s++) begin
         w_rd[s] = '0;
         if (w_src[s] == ZR)
            w_rd[s] = '0;
         else if (r_x_valid && w_x_wr_en && (r_x_write_reg == w_src[s]))
            w_rd[s] = w_alu_result;
         else if (r_out_valid && r_w_reg_write && (r_out_write_reg == w_src[s]))
            w_rd[s] = r_out_result;
         else if ({1'b0, w_src[s]} < NREGS)
            w_rd[s] = r_regs[w_src[s]];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < REG_COUNT; i++)
            r_regs[i] <= '0;
      end else if (w_retire_wr) begin
         r_regs[r_out_write_reg] <= r_out_result;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_x_valid     <= 1'b0;
         r_x_a         <= '0;
         r_x_b         <= '0;
         r_x_alu_op    <= '0;
         r_x_opcode    <= '0;
         r_x_write_reg <= '0;
         r_x_reg_write <= 1'b0;
      end else if (w_in_ready) begin
         r_x_valid <= in_valid;
         if (w_accept) begin
            r_x_a         <= w_rd[0];
            r_x_b         <= in_use_imm ? in_imm : w_rd[1];
            r_x_alu_op    <= in_alu_op;
            r_x_opcode    <= in_opcode;
            r_x_write_reg <= in_write_reg;
            r_x_reg_write <= in_reg_write;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid     <= 1'b0;
         r_out_result    <= '0;
         r_out_zero      <= 1'b0;
         r_out_illegal   <= 1'b0;
         r_out_write_reg <= '0;
         r_w_reg_write   <= 1'b0;
      end else if (w_free) begin
         r_out_valid <= r_x_valid;
         if (w_x_adv) begin
            r_out_result    <= w_alu_result;
            r_out_zero      <= w_alu_zero;
            r_out_illegal   <= w_alu_illegal;
            r_out_write_reg <= r_x_write_reg;
            r_w_reg_write   <= w_x_wr_en;
         end
      end
   end

   alu_core #(
      .DATA_W (DATA_W)
   ) u_alu (
      .i_a       (r_x_a),
      .i_b       (r_x_b),
      .i_alu_op  (r_x_alu_op),
      .i_opcode  (r_x_opcode),
      .o_result  (w_alu_result),
      .o_zero    (w_alu_zero),
      .o_illegal (w_alu_illegal)
   );

   assign in_ready      = w_in_ready;
   assign out_valid     = r_out_valid;
   assign out_result    = r_out_result;
   assign out_zero      = r_out_zero;
   assign out_illegal   = r_out_illegal;
   assign out_write_reg = r_out_write_reg;

endmodule
